rs485_top: RTL and testbench
============================

// Module: rs485_top
// PURPOSE
// - Half-duplex 8N1 UART core for the RS485 transceiver: serialises bytes onto txd and deserialises rxd.
// - Pin-selectable baud rate.
// - Supplies tx_ready, which the top level inverts to drive the transceiver DE/RE pins.
// - Sits between main_controller / ROM_READ (byte sources) and the DI/RO pins.
// PARAMETERS
// - CLK_FREQ    50_000_000  system clock frequency in Hz.
// - R2T_BITS    2           receive-to-transmit guard time, in bit periods.
// PORTS
// - clock             in   1  system clock; all logic on the rising edge.
// - reset             in   1  synchronous, active-high reset.
// - txd               out  1  serial transmit line (to DI); idles high.
// - rxd               in   1  serial receive line (from RO); asynchronous input.
// - tx_cmd            in   1  transmit request; level-sensitive.
// - tx_ready          out  1  1 = transmitter idle and able to accept a byte.
// - tx_data           in   8  byte to transmit; sampled on acceptance.
// - r2tdelay_en       out  1  1 while the receive-to-transmit guard interval runs.
// - rx_ready          out  1  one-cycle pulse when a valid byte is received.
// - rx_data           out  8  last received byte.
// - i_pin_br_val_set  in   2  baud select: 00=9600, 01=38400, 10=115200, 11=230400.
// - tp                out  8  debug: {tx_state[3:0], rx_state[3:0]}.
// BEHAVIOUR
// - Reset values: txd=1, tx_ready=1, rx_ready=0, rx_data=0, r2tdelay_en=0, tp=0; both FSMs go to IDLE.
// - Bit period:
//   - DIV = CLK_FREQ/baud, integer division; one bit lasts DIV clocks.
//   - i_pin_br_val_set is latched at the start of each TX or RX frame.
//   - A baud change mid-frame has no effect on the frame in progress.
// - TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
//   - Acceptance: in IDLE, tx_cmd=1 and r2tdelay_en=0 on an edge latches tx_data.
//   - The next cycle tx_ready=0 and txd=0 (start bit).
//   - Frame: start bit 0, data bits LSB first, one stop bit 1; each bit lasts DIV clocks.
//   - tx_ready returns to 1 in the cycle after the stop bit completes.
//   - If tx_cmd is still high then, a new frame starts one cycle later with the current tx_data.
//   - tx_cmd while tx_ready=0 is ignored. Changes to tx_data after acceptance do not affect the frame.
// - RX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
//   - rxd passes through a 2-flop synchroniser.
//   - In IDLE, a 1->0 edge starts a frame.
//   - At DIV/2 the start bit is re-checked; if rxd=1, return to IDLE without output.
//   - Each data bit is sampled DIV clocks after the previous sample, mid-bit, LSB first.
//   - Stop sample = 1: rx_data is updated and rx_ready pulses high for exactly one cycle.
//   - Stop sample = 0 (framing error): the byte is discarded, no rx_ready, rx_data is unchanged.
//   - While tx_ready=0 the receiver is held in IDLE and ignores rxd; the line is not driven by the far end.
// - Receive-to-transmit guard:
//   - After every valid stop bit, r2tdelay_en=1 for R2T_BITS*DIV clocks, then 0.
//   - tx_cmd is not accepted while r2tdelay_en=1; tx_ready stays 1.
//   - A new start edge during the guard restarts reception; the guard restarts after that frame.
// - Reset mid-frame: immediate return to the reset values on the next edge; a partial byte is never reported.
// - Counters are wide enough for DIV at 9600 baud; no overflow at any setting.
// TESTING
// - General setup: CLK_FREQ=1_152_000, select 10, so DIV=10.
// - Reset: after reset, txd=1, tx_ready=1, rx_ready=0, rx_data=0, r2tdelay_en=0.
// - TX single byte: pulse tx_cmd with tx_data=0xA5.
//   - tx_ready falls the next cycle.
//   - txd = 0,1,0,1,0,0,1,0,1,1, each bit lasting 10 clocks.
//   - tx_ready=1 after 100 clocks.
// - TX back-to-back: hold tx_cmd=1, tx_data 0x55 then 0x0F.
//   - Two contiguous frames, separated by a single tx_ready=1 cycle.
//   - The second frame carries 0x0F.
// - RX valid: drive frame 0x3C at DIV=10.
//   - One rx_ready pulse, rx_data=0x3C.
//   - r2tdelay_en=1 for 20 clocks.
//   - A tx_cmd during that window is accepted only after it ends.
// - RX errors:
//   - A 3-clock glitch low on rxd produces no rx_ready.
//   - Frame 0x81 with stop bit 0 produces no rx_ready; rx_data keeps its previous value.
// - Baud select: with CLK_FREQ=46_080_000, select 00 gives a 4800-clock bit and 11 gives a 200-clock bit.
//   - Changing the select mid-frame does not alter the current frame.

Source files
------------

// File: rtl/rs485_top.sv
// Half-duplex 8N1 UART core for the RS485 transceiver with pin-selectable baud
// rate and a receive-to-transmit guard interval.
module rs485_top #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned R2T_BITS = 2
) (
  input  logic       clock,
  input  logic       reset,
  output logic       txd,
  input  logic       rxd,
  input  logic       tx_cmd,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       r2tdelay_en,
  output logic       rx_ready,
  output logic [7:0] rx_data,
  input  logic [1:0] i_pin_br_val_set,
  output logic [7:0] tp
);

  localparam int unsigned DIV_9600   = CLK_FREQ / 9600;
  localparam int unsigned DIV_38400  = CLK_FREQ / 38400;
  localparam int unsigned DIV_115200 = CLK_FREQ / 115200;
  localparam int unsigned DIV_230400 = CLK_FREQ / 230400;
  localparam int unsigned CW_RAW     = $clog2(DIV_9600 + 1);
  localparam int unsigned CW         = (CW_RAW == 0) ? 1 : CW_RAW;
  localparam int unsigned GW_RAW     = $clog2(R2T_BITS * DIV_9600 + 1);
  localparam int unsigned GW         = (GW_RAW == 0) ? 1 : GW_RAW;
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [3:0] {
    TX_IDLE  = 4'd0,
    TX_START = 4'd1,
    TX_DATA  = 4'd2,
    TX_STOP  = 4'd3
  } tx_state_t;

  typedef enum logic [3:0] {
    RX_IDLE  = 4'd0,
    RX_START = 4'd1,
    RX_DATA  = 4'd2,
    RX_STOP  = 4'd3
  } rx_state_t;

  // Bit period for the currently selected baud; latched at frame start.
  logic [CW-1:0] div_sel;

  always_comb begin
    div_sel = CW'(DIV_9600);
    case (i_pin_br_val_set)
      2'b00:   div_sel = CW'(DIV_9600);
      2'b01:   div_sel = CW'(DIV_38400);
      2'b10:   div_sel = CW'(DIV_115200);
      default: div_sel = CW'(DIV_230400);
    endcase
  end

  // ---------------- transmitter ----------------
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [CW-1:0] tx_div, tx_div_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          txd_q, txd_n;
  logic          tx_bit_done;

  assign tx_ready    = (tx_state == TX_IDLE);
  assign txd         = txd_q;
  assign tx_bit_done = (tx_cnt == tx_div - ONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd_q    <= txd_n;
    end
  end

  // txd is registered from the next-state decode so the pin never glitches.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = txd_q;
    case (tx_state)
      TX_IDLE: begin
        txd_n = 1'b1;
        if (tx_cmd && !r2tdelay_en) begin
          tx_state_n = TX_START;
          tx_shift_n = tx_data;
          tx_div_n   = div_sel;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          txd_n      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_done) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          txd_n      = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt + ONE;
        end
      end
      TX_DATA: begin
        if (tx_bit_done) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            txd_n      = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            txd_n      = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + ONE;
        end
      end
      TX_STOP: begin
        if (tx_bit_done) begin
          tx_state_n = TX_IDLE;
          tx_cnt_n   = '0;
          txd_n      = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + ONE;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        txd_n      = 1'b1;
      end
    endcase
  end

  // ---------------- receiver ----------------
  logic          rxd_s1, rxd_s2, rxd_prev;
  logic          rx_fall;
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [CW-1:0] rx_div, rx_div_n;
  logic [CW-1:0] rx_half_m1;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_valid;
  logic          rx_bit_done;
  logic [7:0]    rx_data_q;
  logic          rx_ready_q;

  assign rx_fall     = rxd_prev & ~rxd_s2;
  assign rx_half_m1  = (rx_div >> 1) - ONE;
  assign rx_bit_done = (rx_cnt == rx_div - ONE);
  assign rx_data     = rx_data_q;
  assign rx_ready    = rx_ready_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_div     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_div     <= rx_div_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
      rx_ready_q <= rx_valid;
      if (rx_valid) begin
        rx_data_q <= rx_shift;
      end
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_div_n   = rx_div;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_valid   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_n = RX_START;
          rx_div_n   = div_sel;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == rx_half_m1) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rxd_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + ONE;
        end
      end
      RX_DATA: begin
        if (rx_bit_done) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rxd_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) begin
            rx_state_n = RX_STOP;
          end else begin
            rx_bit_n = rx_bit + 3'd1;
          end
        end else begin
          rx_cnt_n = rx_cnt + ONE;
        end
      end
      RX_STOP: begin
        if (rx_bit_done) begin
          rx_state_n = RX_IDLE;
          rx_cnt_n   = '0;
          rx_valid   = rxd_s2;
        end else begin
          rx_cnt_n = rx_cnt + ONE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
    // Our own transmission owns the line; the far end is not driving it.
    if (!tx_ready) begin
      rx_state_n = RX_IDLE;
    end
  end

  // ---------------- receive-to-transmit guard ----------------
  logic [GW-1:0] guard_cnt;
  logic [GW-1:0] guard_load;
  logic          r2t_q;

  assign guard_load  = GW'(R2T_BITS * rx_div) - GW'(1);
  assign r2tdelay_en = r2t_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r2t_q     <= 1'b0;
      guard_cnt <= '0;
    end else if (rx_valid && (R2T_BITS != 0)) begin
      r2t_q     <= 1'b1;
      guard_cnt <= guard_load;
    end else if (r2t_q) begin
      if (guard_cnt == '0) begin
        r2t_q <= 1'b0;
      end else begin
        guard_cnt <= guard_cnt - GW'(1);
      end
    end
  end

  assign tp = {tx_state, rx_state};

endmodule

// File: tb/tb_rs485_top.sv
// Directed bench for rs485_top: DUT A at DIV=10 (1.152 MHz, 115200 baud),
// DUT B at 46.08 MHz for baud-select timing.
module tb_rs485_top;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst_a, txd_a, rxd_a, tx_cmd_a, tx_ready_a, r2t_a, rx_ready_a;
  logic [7:0] tx_data_a, rx_data_a, tp_a;
  logic [1:0] sel_a;

  logic       rst_b, txd_b, rxd_b, tx_cmd_b, tx_ready_b, r2t_b, rx_ready_b;
  logic [7:0] tx_data_b, rx_data_b, tp_b;
  logic [1:0] sel_b;

  rs485_top #(.CLK_FREQ(1_152_000), .R2T_BITS(2)) dut_a (
    .clock(clk), .reset(rst_a), .txd(txd_a), .rxd(rxd_a), .tx_cmd(tx_cmd_a),
    .tx_ready(tx_ready_a), .tx_data(tx_data_a), .r2tdelay_en(r2t_a),
    .rx_ready(rx_ready_a), .rx_data(rx_data_a), .i_pin_br_val_set(sel_a), .tp(tp_a)
  );

  rs485_top #(.CLK_FREQ(46_080_000), .R2T_BITS(2)) dut_b (
    .clock(clk), .reset(rst_b), .txd(txd_b), .rxd(rxd_b), .tx_cmd(tx_cmd_b),
    .tx_ready(tx_ready_b), .tx_data(tx_data_b), .r2tdelay_en(r2t_b),
    .rx_ready(rx_ready_b), .rx_data(rx_data_b), .i_pin_br_val_set(sel_b), .tp(tp_b)
  );

  // Line level of bit idx (0=start, 1..8=data LSB first, 9=stop).
  function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int idx);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    return fr[idx[3:0]];
  endfunction

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    rxd_a = 1'b1; rxd_b = 1'b1;
    tx_cmd_a = 1'b0; tx_cmd_b = 1'b0;
    tx_data_a = 8'h00; tx_data_b = 8'h00;
    sel_a = 2'b10; sel_b = 2'b00;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd_a); end
    checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready_a); end
    checks++; if (rx_ready_a !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready_a); end
    checks++; if (rx_data_a !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data_a); end
    checks++; if (r2t_a !== 1'b0) begin errors++; $display("FAIL reset_r2t: got %b expected 0", r2t_a); end
    checks++; if (tp_a !== 8'h00) begin errors++; $display("FAIL reset_tp: got %h expected 00", tp_a); end
  endtask

  task automatic test_tx_single();
    tx_data_a = 8'hA5; tx_cmd_a = 1'b1;
    @(negedge clk);
    tx_cmd_a = 1'b0; tx_data_a = 8'h00;
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (txd_a !== frame_bit(8'hA5, 1'b1, k / 10)) begin
        errors++; $display("FAIL tx_single_txd[%0d]: got %b expected %b", k, txd_a, frame_bit(8'hA5, 1'b1, k / 10));
      end
      checks++;
      if (tx_ready_a !== 1'b0) begin errors++; $display("FAIL tx_single_busy[%0d]: got %b expected 0", k, tx_ready_a); end
      @(negedge clk);
    end
    checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("FAIL tx_single_done: got %b expected 1", tx_ready_a); end
    checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL tx_single_idle_txd: got %b expected 1", txd_a); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    tx_data_a = 8'h55; tx_cmd_a = 1'b1;
    @(negedge clk);
    tx_data_a = 8'h0F;
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (txd_a !== frame_bit(8'h55, 1'b1, k / 10)) begin
        errors++; $display("FAIL b2b_first_txd[%0d]: got %b expected %b", k, txd_a, frame_bit(8'h55, 1'b1, k / 10));
      end
      @(negedge clk);
    end
    checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("FAIL b2b_gap_ready: got %b expected 1", tx_ready_a); end
    @(negedge clk);
    tx_cmd_a = 1'b0;
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (txd_a !== frame_bit(8'h0F, 1'b1, k / 10)) begin
        errors++; $display("FAIL b2b_second_txd[%0d]: got %b expected %b", k, txd_a, frame_bit(8'h0F, 1'b1, k / 10));
      end
      checks++;
      if (tx_ready_a !== 1'b0) begin errors++; $display("FAIL b2b_second_busy[%0d]: got %b expected 0", k, tx_ready_a); end
      @(negedge clk);
    end
    checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", tx_ready_a); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rx_valid();
    int n_rdy = 0, n_en = 0, gap = 0, overlap = 0, acc_i = -1, en_at_acc = -1, n = 0;
    logic [7:0] rdy_data = 8'h00;
    for (int i = 0; i < 200; i++) begin
      rxd_a = (i < 100) ? frame_bit(8'h3C, 1'b1, i / 10) : 1'b1;
      @(negedge clk);
      if (rx_ready_a) begin n_rdy++; rdy_data = rx_data_a; end
      if (r2t_a) begin
        n_en++;
        tx_cmd_a = 1'b1; tx_data_a = 8'hC3;
        if (!tx_ready_a) overlap++;
      end else if (n_en > 0 && acc_i < 0 && tx_ready_a) begin
        gap++;
      end
      if (acc_i < 0 && !tx_ready_a) begin
        acc_i = i; en_at_acc = n_en; tx_cmd_a = 1'b0;
      end
    end
    tx_cmd_a = 1'b0;
    checks++; if (n_rdy !== 1) begin errors++; $display("FAIL rx_valid_pulses: got %0d expected 1", n_rdy); end
    checks++; if (rdy_data !== 8'h3C) begin errors++; $display("FAIL rx_valid_data_at_pulse: got %h expected 3c", rdy_data); end
    checks++; if (rx_data_a !== 8'h3C) begin errors++; $display("FAIL rx_valid_data: got %h expected 3c", rx_data_a); end
    checks++; if (n_en !== 20) begin errors++; $display("FAIL rx_guard_len: got %0d expected 20", n_en); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL rx_guard_tx_blocked: got %0d accepted-in-guard expected 0", overlap); end
    checks++; if (en_at_acc !== 20) begin errors++; $display("FAIL rx_guard_acc_after: got %0d expected 20", en_at_acc); end
    checks++; if (gap !== 1) begin errors++; $display("FAIL rx_guard_acc_gap: got %0d expected 1", gap); end
    while (!tx_ready_a && n < 300) begin n++; @(negedge clk); end
    checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("FAIL rx_guard_tx_finish: got %b expected 1", tx_ready_a); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_rx_errors();
    int n_rdy = 0, n_en = 0;
    for (int i = 0; i < 40; i++) begin
      rxd_a = (i < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rx_ready_a) n_rdy++;
      if (r2t_a) n_en++;
    end
    checks++; if (n_rdy !== 0) begin errors++; $display("FAIL glitch_rx_ready: got %0d expected 0", n_rdy); end
    checks++; if (n_en !== 0) begin errors++; $display("FAIL glitch_guard: got %0d expected 0", n_en); end
    checks++; if (tp_a[3:0] !== 4'h0) begin errors++; $display("FAIL glitch_rx_idle: got %h expected 0", tp_a[3:0]); end
    n_rdy = 0; n_en = 0;
    for (int i = 0; i < 150; i++) begin
      rxd_a = (i < 100) ? frame_bit(8'h81, 1'b0, i / 10) : 1'b1;
      @(negedge clk);
      if (rx_ready_a) n_rdy++;
      if (r2t_a) n_en++;
    end
    checks++; if (n_rdy !== 0) begin errors++; $display("FAIL framing_rx_ready: got %0d expected 0", n_rdy); end
    checks++; if (rx_data_a !== 8'h3C) begin errors++; $display("FAIL framing_rx_data: got %h expected 3c", rx_data_a); end
    checks++; if (n_en !== 0) begin errors++; $display("FAIL framing_guard: got %0d expected 0", n_en); end
    n_rdy = 0;
    for (int i = 0; i < 130; i++) begin
      rxd_a = (i < 100) ? frame_bit(8'h81, 1'b1, i / 10) : 1'b1;
      @(negedge clk);
      if (rx_ready_a) n_rdy++;
    end
    checks++; if (n_rdy !== 1) begin errors++; $display("FAIL recover_rx_ready: got %0d expected 1", n_rdy); end
    checks++; if (rx_data_a !== 8'h81) begin errors++; $display("FAIL recover_rx_data: got %h expected 81", rx_data_a); end
  endtask

  task automatic test_baud();
    int n = 0, nlow = 0;
    sel_b = 2'b00; tx_data_b = 8'hFF; tx_cmd_b = 1'b1;
    @(negedge clk);
    tx_cmd_b = 1'b0;
    while (txd_b === 1'b0 && n < 10000) begin n++; @(negedge clk); end
    checks++; if (n !== 4800) begin errors++; $display("FAIL baud00_start_len: got %0d expected 4800", n); end
    rst_b = 1'b1;
    @(negedge clk);
    checks++; if (txd_b !== 1'b1) begin errors++; $display("FAIL midframe_reset_txd: got %b expected 1", txd_b); end
    checks++; if (tx_ready_b !== 1'b1) begin errors++; $display("FAIL midframe_reset_ready: got %b expected 1", tx_ready_b); end
    checks++; if (tp_b !== 8'h00) begin errors++; $display("FAIL midframe_reset_tp: got %h expected 00", tp_b); end
    rst_b = 1'b0;
    @(negedge clk);
    sel_b = 2'b11; tx_cmd_b = 1'b1;
    @(negedge clk);
    tx_cmd_b = 1'b0; sel_b = 2'b00;
    n = 0;
    while (!tx_ready_b && n < 10000) begin
      n++;
      if (!txd_b) nlow++;
      @(negedge clk);
    end
    checks++; if (nlow !== 200) begin errors++; $display("FAIL baud11_start_len: got %0d expected 200", nlow); end
    checks++; if (n !== 2000) begin errors++; $display("FAIL baud11_frame_len: got %0d expected 2000", n); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_valid();
    test_rx_errors();
    test_baud();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
